mem_arbiter: RTL and testbench

Two-master arbiter for the native valid/ready memory bus. It shares the single slave-side bus (address decoder, ready OR and rdata mux) between the CPU (master 0) and a DMA or debug master (master 1). Grants are round-robin, and an ownership lock holds each grant until its transaction completes. A watchdog terminates any transaction that no slave answers, so an unmapped address cannot hang either master.

---
 rtl/mem_bus_pkg.sv | 28 ++
 rtl/bus_watchdog.sv | 30 +++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the native valid/ready memory bus.
package mem_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  // Arbiter FSM encoding
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Master indices as seen on the owner/err_master outputs
  localparam logic MASTER_CPU = 1'b0;
  localparam logic MASTER_DMA = 1'b1;

  // Read data returned when the watchdog forces a completion
  localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  // Request payload forwarded from the owning master to the slave side
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } bus_req_t;

endpackage

// File: rtl/bus_watchdog.sv
// Wait-cycle counter for a granted transaction; flags the terminal cycle.
module bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count;

  // Count stalled cycles; restart at each new grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  // Terminal count reached: this is the last cycle the slave may answer
  assign expired = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin / fixed-priority arbiter with ownership lock and
// a watchdog that force-completes transactions no slave answers.
module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned        TIMEOUT_CYCLES = 64,
  parameter logic [DATA_W-1:0]  ERR_RDATA      = ERR_RDATA_DEFAULT,
  parameter bit                 ROUND_ROBIN    = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_valid,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              owner,
  output logic              timeout_irq,
  output logic              err_master
);

  arb_state_e state, state_nxt;
  logic       owner_q;
  logic       irq_q;
  logic       err_q;
  logic       grant_sel;
  logic       any_req;
  logic       grant_now;
  logic       busy;
  logic       own_valid;
  logic       wd_expired;
  logic       done_ok;
  logic       tmo_fire;
  bus_req_t   req0, req1, own_req;

  assign req0      = '{addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
  assign req1      = '{addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};
  assign own_req   = owner_q ? req1 : req0;
  assign own_valid = owner_q ? m1_valid : m0_valid;
  assign any_req   = m0_valid | m1_valid;
  assign busy      = (state == ST_BUSY);
  assign grant_now = (state == ST_IDLE) & any_req;
  assign done_ok   = busy & own_valid & s_ready;
  assign tmo_fire  = busy & own_valid & ~s_ready & wd_expired;

  // Pick the next owner; owner_q doubles as "last granted" for round-robin
  always_comb begin
    grant_sel = owner_q;
    if (m0_valid && m1_valid) begin
      grant_sel = ROUND_ROBIN ? ~owner_q : MASTER_CPU;
    end else if (m0_valid) begin
      grant_sel = MASTER_CPU;
    end else if (m1_valid) begin
      grant_sel = MASTER_DMA;
    end
  end

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (grant_now),
    .enable (busy & ~s_ready),
    .expired(wd_expired)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: any completion, abort or timeout returns to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (any_req) state_nxt = ST_BUSY;
      ST_BUSY: if (!own_valid || s_ready || wd_expired) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Grant, irq and sticky error-master registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q <= MASTER_DMA;
      irq_q   <= 1'b0;
      err_q   <= MASTER_CPU;
    end else begin
      irq_q <= tmo_fire;
      if (tmo_fire) err_q <= owner_q;
      if (grant_now) owner_q <= grant_sel;
    end
  end

  // FSM outputs: forward owner's request, route completion back to it.
  // s_valid stays up in the terminal cycle if the slave answers, so a late
  // s_ready still reads as a normal completion.
  always_comb begin
    s_valid  = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    if (busy) begin
      s_valid = own_valid & ~(wd_expired & ~s_ready);
      s_addr  = own_req.addr;
      s_wdata = own_req.wdata;
      s_wstrb = own_req.wstrb;
      if (done_ok || tmo_fire) begin
        if (owner_q) begin
          m1_ready = 1'b1;
          m1_rdata = s_ready ? s_rdata : ERR_RDATA;
        end else begin
          m0_ready = 1'b1;
          m0_rdata = s_ready ? s_rdata : ERR_RDATA;
        end
      end
    end
  end

  assign owner       = owner_q;
  assign timeout_irq = irq_q;
  assign err_master  = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a fixed-priority instance share
// one stimulus stream and are both checked every cycle against a
// transaction-level model, plus hand-computed directed expectations.
module tb_mem_arbiter;

  localparam int unsigned TMO = 64;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk;
  logic        reset_n;
  logic        m0_valid, m1_valid, s_ready;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;

  logic [1:0]  o_m0_ready, o_m1_ready, o_s_valid, o_owner, o_irq, o_err;
  logic [31:0] o_m0_rdata [2];
  logic [31:0] o_m1_rdata [2];
  logic [31:0] o_s_addr   [2];
  logic [31:0] o_s_wdata  [2];
  logic [3:0]  o_s_wstrb  [2];

  int tests = 0;
  int fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYCLES(TMO), .ERR_RDATA(ERR), .ROUND_ROBIN(1'b1)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(o_m0_ready[0]), .m0_rdata(o_m0_rdata[0]),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(o_m1_ready[0]), .m1_rdata(o_m1_rdata[0]),
    .s_valid(o_s_valid[0]), .s_addr(o_s_addr[0]), .s_wdata(o_s_wdata[0]), .s_wstrb(o_s_wstrb[0]),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .owner(o_owner[0]), .timeout_irq(o_irq[0]), .err_master(o_err[0])
  );

  mem_arbiter #(.TIMEOUT_CYCLES(TMO), .ERR_RDATA(ERR), .ROUND_ROBIN(1'b0)) u_fp (
    .clk(clk), .reset_n(reset_n),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(o_m0_ready[1]), .m0_rdata(o_m0_rdata[1]),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(o_m1_ready[1]), .m1_rdata(o_m1_rdata[1]),
    .s_valid(o_s_valid[1]), .s_addr(o_s_addr[1]), .s_wdata(o_s_wdata[1]), .s_wstrb(o_s_wstrb[1]),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .owner(o_owner[1]), .timeout_irq(o_irq[1]), .err_master(o_err[1])
  );

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %h, expected %h (t=%0t)", name, inst, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // Per instance: is a transaction open, who owns it (== last granted),
  // the cycle it started, and the irq/err registers.
  bit     rr_mode [2] = '{1'b1, 1'b0};
  bit     m_busy  [2];
  bit     m_own   [2];
  bit     m_irq   [2];
  bit     m_err   [2];
  int     m_start [2];
  int     cyc;

  typedef struct packed {
    logic        s_valid;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  rdy;
    logic [31:0] rd;
    logic        timeout;
    logic        finish;
  } exp_t;

  // Expected combinational outputs this cycle, from elapsed cycles since grant
  function automatic exp_t expect_out(input int i);
    exp_t e;
    logic ov;
    int   waited;
    e = '0;
    if (m_busy[i]) begin
      ov        = m_own[i] ? m1_valid : m0_valid;
      waited    = cyc - m_start[i];
      e.timeout = ov && !s_ready && (waited >= int'(TMO) - 1);
      e.finish  = !ov || s_ready || e.timeout;
      e.s_valid = ov && !e.timeout;
      e.s_addr  = m_own[i] ? m1_addr  : m0_addr;
      e.s_wdata = m_own[i] ? m1_wdata : m0_wdata;
      e.s_wstrb = m_own[i] ? m1_wstrb : m0_wstrb;
      if (ov && (s_ready || e.timeout)) begin
        e.rdy[m_own[i]] = 1'b1;
        e.rd            = s_ready ? s_rdata : ERR;
      end
    end
    return e;
  endfunction

  // Advance the model on each clock edge; async reset clears it
  always @(posedge clk or negedge reset_n) begin : model_upd
    exp_t e;
    if (!reset_n) begin
      cyc <= 0;
      for (int i = 0; i < 2; i++) begin
        m_busy[i] <= 1'b0; m_own[i] <= 1'b1; m_irq[i] <= 1'b0;
        m_err[i] <= 1'b0;  m_start[i] <= 0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
        e = expect_out(i);
        if (!m_busy[i]) begin
          m_irq[i] <= 1'b0;
          if (m0_valid || m1_valid) begin
            m_busy[i]  <= 1'b1;
            m_start[i] <= cyc + 1;
            if (m0_valid && m1_valid) m_own[i] <= rr_mode[i] ? !m_own[i] : 1'b0;
            else                      m_own[i] <= m1_valid;
          end
        end else begin
          m_irq[i] <= e.timeout;
          if (e.timeout) m_err[i] <= m_own[i];
          if (e.finish)  m_busy[i] <= 1'b0;
        end
      end
    end
  end

  // Compare every DUT output against the model mid-cycle
  always @(negedge clk) begin : compare
    exp_t e;
    if (reset_n) begin
      for (int i = 0; i < 2; i++) begin
        e = expect_out(i);
        check("s_valid",  i, 32'(o_s_valid[i]), 32'(e.s_valid));
        check("s_addr",   i, o_s_addr[i], e.s_addr);
        check("s_wdata",  i, o_s_wdata[i], e.s_wdata);
        check("s_wstrb",  i, 32'(o_s_wstrb[i]), 32'(e.s_wstrb));
        check("m0_ready", i, 32'(o_m0_ready[i]), 32'(e.rdy[0]));
        check("m1_ready", i, 32'(o_m1_ready[i]), 32'(e.rdy[1]));
        if (e.rdy[0]) check("m0_rdata", i, o_m0_rdata[i], e.rd);
        else if (!(m_busy[i] && !m_own[i])) check("m0_rdata_idle", i, o_m0_rdata[i], 32'h0);
        if (e.rdy[1]) check("m1_rdata", i, o_m1_rdata[i], e.rd);
        else if (!(m_busy[i] && m_own[i])) check("m1_rdata_idle", i, o_m1_rdata[i], 32'h0);
        check("owner",    i, 32'(o_owner[i]), 32'(m_own[i]));
        check("irq",      i, 32'(o_irq[i]), 32'(m_irq[i]));
        check("err_mstr", i, 32'(o_err[i]), 32'(m_err[i]));
      end
    end
  end

  // Record who completed each transaction during contention runs
  bit collect = 1'b0;
  bit q_own0[$];
  bit q_own1[$];
  always @(negedge clk) begin
    if (collect && reset_n && s_ready) begin
      if (o_s_valid[0]) q_own0.push_back(o_owner[0]);
      if (o_s_valid[1]) q_own1.push_back(o_owner[1]);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int rise;
    int rdy;
    reset_n = 1'b0;
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    m0_wstrb = '0; m1_wstrb = '0;
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      check("rst_owner",   i, 32'(o_owner[i]), 32'd1);
      check("rst_s_valid", i, 32'(o_s_valid[i]), 32'd0);
      check("rst_irq",     i, 32'(o_irq[i]), 32'd0);
      check("rst_err",     i, 32'(o_err[i]), 32'd0);
      check("rst_ready",   i, 32'({o_m0_ready[i], o_m1_ready[i]}), 32'd0);
      check("rst_s_addr",  i, o_s_addr[i], 32'h0);
    end
    @(posedge clk); #1 reset_n = 1'b1;

    // Single master read, zero-wait slave
    m0_valid = 1'b1; m0_addr = 32'h0002_0000; m0_wstrb = 4'h0;
    step(1);
    s_ready = 1'b1; s_rdata = 32'h1234_5678;
    #1;
    check("t1_s_valid",  0, 32'(o_s_valid[0]), 32'd1);
    check("t1_s_addr",   0, o_s_addr[0], 32'h0002_0000);
    check("t1_m0_ready", 0, 32'(o_m0_ready[0]), 32'd1);
    check("t1_m0_rdata", 0, o_m0_rdata[0], 32'h1234_5678);
    check("t1_m1_ready", 0, 32'(o_m1_ready[0]), 32'd0);
    step(1);
    m0_valid = 1'b0; s_ready = 1'b0;
    #1 check("t1_no_ready", 0, 32'(o_m0_ready[0]), 32'd0);

    // Abort: owner drops valid before the slave answers
    m0_valid = 1'b1; m0_addr = 32'h0000_0100;
    step(1);
    m0_valid = 1'b0;
    #1;
    check("abort_ready",   0, 32'(o_m0_ready[0]), 32'd0);
    check("abort_s_valid", 0, 32'(o_s_valid[0]), 32'd0);
    step(2);

    // Timeout on an unmapped write from m1
    m1_valid = 1'b1; m1_addr = 32'h9000_0000; m1_wdata = 32'hA5A5_0001; m1_wstrb = 4'hF;
    rise = -1; rdy = -1;
    for (int k = 0; k < 100; k++) begin
      step(1); #1;
      if (rise < 0 && o_s_valid[0]) rise = k;
      if (o_m1_ready[0]) begin
        rdy = k;
        break;
      end
    end
    check("tmo_latency", 0, 32'(rdy - rise), 32'(TMO - 1));
    check("tmo_rdata",   0, o_m1_rdata[0], 32'hDEAD_BEEF);
    check("tmo_s_valid", 0, 32'(o_s_valid[0]), 32'd0);
    step(1);
    m1_valid = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("tmo_irq", i, 32'(o_irq[i]), 32'd1);
      check("tmo_err", i, 32'(o_err[i]), 32'd1);
    end
    step(1); #1;
    check("tmo_irq_pulse", 0, 32'(o_irq[0]), 32'd0);

    // Race: slave answers in the terminal watchdog cycle
    m0_valid = 1'b1; m0_addr = 32'h0000_3000; m0_wstrb = 4'h0;
    for (int k = 0; k < 5; k++) begin
      step(1); #1;
      if (o_s_valid[0]) break;
    end
    step(TMO - 1);
    s_ready = 1'b1; s_rdata = 32'hCAFE_F00D;
    #1;
    check("race_ready", 0, 32'(o_m0_ready[0]), 32'd1);
    check("race_rdata", 0, o_m0_rdata[0], 32'hCAFE_F00D);
    step(1);
    m0_valid = 1'b0; s_ready = 1'b0;
    #1;
    check("race_no_irq", 0, 32'(o_irq[0]), 32'd0);
    check("race_err_sticky", 0, 32'(o_err[0]), 32'd1);

    // Reset while BUSY
    m1_valid = 1'b1; m1_addr = 32'h0000_0044;
    step(2);
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rstmid_s_valid", i, 32'(o_s_valid[i]), 32'd0);
      check("rstmid_ready",   i, 32'(o_m1_ready[i]), 32'd0);
      check("rstmid_owner",   i, 32'(o_owner[i]), 32'd1);
    end
    m1_valid = 1'b0;
    step(1);
    reset_n = 1'b1;

    // Contention from reset: RR alternates, fixed priority always m0
    m0_valid = 1'b1; m1_valid = 1'b1;
    m0_addr = 32'h0000_0010; m1_addr = 32'h0000_0020;
    s_ready = 1'b1; s_rdata = 32'h5555_AAAA;
    collect = 1'b1;
    step(40);
    collect = 1'b0;
    check("rr_count", 0, 32'(q_own0.size() >= 10), 32'd1);
    check("fp_count", 1, 32'(q_own1.size() >= 10), 32'd1);
    for (int k = 0; k < 10 && k < q_own0.size(); k++)
      check("rr_grant_seq", 0, 32'(q_own0[k]), 32'(k % 2));
    for (int k = 0; k < 10 && k < q_own1.size(); k++)
      check("fp_grant_seq", 1, 32'(q_own1[k]), 32'd0);

    // Fixed priority serves m1 once m0 goes quiet
    q_own1.delete();
    m0_valid = 1'b0;
    collect = 1'b1;
    step(6);
    collect = 1'b0;
    check("fp_m1_served", 1, 32'(q_own1.size() >= 2), 32'd1);
    if (q_own1.size() > 0) check("fp_m1_owner", 1, 32'(q_own1[0]), 32'd1);

    m1_valid = 1'b0; s_ready = 1'b0;
    step(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
